cdc_2phase_src_clearable: RTL and testbench
===========================================

Name: cdc_2phase_src_clearable

Overview:
- Source (sender) half of a clearable two-phase (toggle) clock-domain-crossing channel.
- Accepts items with a valid/ready handshake in its own clock domain.
- Launches each item as a toggle on async_req_o, with the payload held stable on async_data_o.
- Waits for the destination's acknowledge toggle, synchronised into this domain, before it accepts the next item.
- A synchronous clear returns the handshake to its idle phase. Clear is coordinated with the destination half by an external clear synchroniser.

Parameters:
- T, default logic (1 bit): payload type; widths below written as |T| (32 in the standard instance).
- SYNC_STAGES, default 2: flip-flop depth of the async_ack_i synchroniser; legal range ≥ 2.

Ports:
- clk_i  input  1  source-domain clock; all flops are rising-edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous clear, active-high, single-cycle or longer.
- data_i  input  |T|  payload to send.
- valid_i  input  1  payload valid.
- ready_o  output  1  channel can accept an item this cycle.
- async_req_o  output  1  request toggle toward the destination domain, registered.
- async_ack_i  input  1  acknowledge toggle from the destination domain, asynchronous.
- async_data_o  output  |T|  payload toward the destination, registered and stable while a request is outstanding.

Behaviour:
- One clock (clk_i); reset is asynchronous and active-low (rst_ni).
- State:
  - req_q: 1 bit, drives async_req_o.
  - data_q: |T|, drives async_data_o.
  - ack_sync: SYNC_STAGES-deep flop chain sampling async_ack_i; its last stage is ack_s.
- Reset (rst_ni=0), effective immediately without waiting for a clock edge:
  - req_q=0, data_q=0, all synchroniser stages=0.
  - Therefore async_req_o=0, async_data_o=0, ready_o=1.
- ready_o is combinational: ready_o = (req_q == ack_s). Phases equal means nothing is outstanding.
- Transfer accepted on a rising edge when valid_i=1, ready_o=1 and clear_i=0. On that edge:
  - req_q <= ~req_q;
  - data_q <= data_i.
- Latency after acceptance:
  - async_req_o and async_data_o update on the accepting edge.
  - ready_o drops in the cycle following acceptance.
  - ready_o returns high SYNC_STAGES rising edges after async_ack_i toggles to match req_q. Any metastability settling is absorbed within the chain.
- No acceptance while ready_o=0. data_q and req_q hold, so async_data_o is stable for the whole outstanding phase.
- valid_i may be asserted with no prior ready_o; valid_i may also drop without a transfer. The block imposes no protocol check on this.
- Clear (clear_i=1 at a rising edge):
  - req_q <= 0.
  - data_q holds its value.
  - The synchroniser is not cleared; it keeps tracking async_ack_i.
  - Clear has priority over a simultaneous valid/ready handshake: the item is not accepted and data_q is not loaded.
- ready_o is not internally masked by clear_i. The wrapper gates ready_o and valid_i with the synchronised clear.
- Clear while a request is outstanding drops that item. The destination half is cleared in the same protocol step and returns its ack to 0, so phases re-align at 0. ready_o recovers at most SYNC_STAGES cycles after ack returns to 0.
- Clear with req_q already 0 has no visible effect.
- Asynchronous reset mid-transfer behaves like clear, plus data_q=0 and the synchroniser flushed to 0.
- No combinational path from async_ack_i to any output except through the synchroniser flops. async_req_o and async_data_o are driven directly from flops (glitch-free).

Test Plan:
- Reset:
  - Stimulus: hold rst_ni=0, drive async_ack_i=1.
  - Response: async_req_o=0, async_data_o=0, ready_o=1 immediately. After release, with ack held at 1 for SYNC_STAGES=2 edges, ready_o=0.
- Single transfer, SYNC_STAGES=2:
  - Stimulus: valid_i=1, data_i=0xDEADBEEF, with async_ack_i=0.
  - Response at the next edge: async_req_o=1, async_data_o=0xDEADBEEF, ready_o=0.
  - Then toggle async_ack_i=1. ready_o=1 exactly 2 edges later.
- Back-to-back transfers:
  - Stimulus: 3 items 0x1, 0x2, 0x3, with async_ack_i mirroring async_req_o after 1 cycle.
  - Response: async_req_o toggles 1,0,1; async_data_o is stable between toggles; no item lost or duplicated.
- Clear with a request outstanding:
  - Stimulus: after sending 0xA5 (req=1, ack=0), pulse clear_i for 1 cycle.
  - Response: async_req_o=0, async_data_o stays 0xA5, ready_o=1 (0==0).
- Clear concurrent with a handshake:
  - Stimulus: valid_i=1, ready_o=1, clear_i=1, data_i=0x55.
  - Response: req_q stays 0 and async_data_o is unchanged.
- Asynchronous reset mid-transfer:
  - Stimulus: assert rst_ni=0 between edges while req=1.
  - Response: async_req_o=0 and async_data_o=0 at once, without a clock edge.

Source files
------------

// File: rtl/cdc_2phase_src_clearable.sv
// Source half of a clearable two-phase (toggle) CDC channel: launches each
// accepted item as a request toggle and waits for the synchronised ack toggle.
module cdc_2phase_src_clearable #(
  parameter type         T           = logic,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output logic async_req_o,
  input  logic async_ack_i,
  output T     async_data_o
);

  logic                   req_q;
  T                       data_q;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   accept;

  assign ack_s  = ack_sync[SYNC_STAGES-1];
  assign accept = valid_i & ready_o & ~clear_i;

  // Matching phases mean nothing is outstanding.
  assign ready_o      = (req_q == ack_s);
  assign async_req_o  = req_q;
  assign async_data_o = data_q;

  // The ack synchroniser is deliberately immune to clear so it keeps tracking
  // the destination while that half returns its ack to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], async_ack_i};
    end
  end

  // Clear wins over a simultaneous handshake and leaves the payload untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= 1'b0;
      data_q <= '0;
    end else if (clear_i) begin
      req_q  <= 1'b0;
    end else if (accept) begin
      req_q  <= ~req_q;
      data_q <= data_i;
    end
  end

endmodule

// File: tb/tb_cdc_2phase_src_clearable.sv
// Directed bench for the clearable two-phase CDC source half (32-bit payload,
// two-stage ack synchroniser).
module tb_cdc_2phase_src_clearable;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        req;
  logic        ack;
  logic [31:0] async_data;

  int tests_run;
  int tests_failed;
  logic exp_req;

  cdc_2phase_src_clearable #(
    .T          (logic [31:0]),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .async_req_o (req),
    .async_ack_i (ack),
    .async_data_o(async_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ack   = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Bounded wait for ready while confirming the payload stays put.
  task automatic wait_ready(input string tag, input logic [31:0] exp_data);
    for (int n = 0; n < 10 && ready !== 1'b1; n++) begin
      step();
      check_output({tag, "_data_stable"}, async_data, exp_data);
    end
    check_output({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  task automatic send(input logic [31:0] value);
    valid = 1'b1;
    data  = value;
    step();
    valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    ack   = 1'b1;
    valid = 1'b0;
    clear = 1'b0;
    data  = '0;

    #3;
    check_output("rst_req",   {31'd0, req}, 32'd0);
    check_output("rst_data",  async_data,   32'd0);
    check_output("rst_ready", {31'd0, ready}, 32'd1);
    step();
    check_output("rst_hold_ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b1;
    step();
    check_output("post_rst_ready_1", {31'd0, ready}, 32'd1);
    step();
    check_output("post_rst_ready_2", {31'd0, ready}, 32'd0);

    // Single transfer
    do_reset();
    send(32'hDEADBEEF);
    check_output("single_req",   {31'd0, req}, 32'd1);
    check_output("single_data",  async_data,   32'hDEADBEEF);
    check_output("single_ready", {31'd0, ready}, 32'd0);
    ack = 1'b1;
    step();
    check_output("single_ack_edge1", {31'd0, ready}, 32'd0);
    step();
    check_output("single_ack_edge2", {31'd0, ready}, 32'd1);

    // Back-to-back, ack mirrors req one cycle later
    do_reset();
    exp_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      send(32'(i));
      exp_req = ~exp_req;
      check_output("b2b_req",  {31'd0, req}, {31'd0, exp_req});
      check_output("b2b_data", async_data,   32'(i));
      step();
      check_output("b2b_req_hold", {31'd0, req}, {31'd0, exp_req});
      ack = exp_req;
      wait_ready("b2b", 32'(i));
    end

    // Clear with a request outstanding
    do_reset();
    send(32'h000000A5);
    check_output("clr_pre_req", {31'd0, req}, 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_output("clr_req",   {31'd0, req}, 32'd0);
    check_output("clr_data",  async_data,   32'h000000A5);
    check_output("clr_ready", {31'd0, ready}, 32'd1);

    // Clear concurrent with a handshake; ready is not masked by clear
    valid = 1'b1;
    clear = 1'b1;
    data  = 32'h00000055;
    #1;
    check_output("clr_hs_ready_unmasked", {31'd0, ready}, 32'd1);
    step();
    valid = 1'b0;
    clear = 1'b0;
    check_output("clr_hs_req",  {31'd0, req}, 32'd0);
    check_output("clr_hs_data", async_data,   32'h000000A5);

    // Asynchronous reset mid-transfer
    send(32'h00000077);
    check_output("arst_pre_req", {31'd0, req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_req",   {31'd0, req}, 32'd0);
    check_output("arst_data",  async_data,   32'd0);
    check_output("arst_ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
